// File: rtl/clint_pkg.sv
// Shared types and constants for the core-local trap sequencer.
package clint_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_MEPC,
    WR_MCAUSE,
    WR_MSTATUS,
    ASSERT_TRAP,
    WR_MSTATUS_RET,
    ASSERT_RET
  } state_t;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  localparam logic [31:0] CAUSE_EXT_IRQ_DEF = 32'h8000_000B;
  localparam logic [31:0] CAUSE_ECALL_DEF   = 32'h0000_000B;
  localparam logic [31:0] CAUSE_EBREAK_DEF  = 32'h0000_0003;

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

endpackage

// File: rtl/clint_ctrl_sync_ff.sv
// N-stage flop synchronizer for a single asynchronous level; clears to 0 on reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the async level through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/clint_ctrl.sv
// Core-local trap sequencer: takes ecall/ebreak/mret/external irq from EX,
// stalls the pipe, writes mepc/mcause/mstatus through the CSR side port,
// then strobes a fetch redirect to mtvec or mepc.
//
// state          | meaning
// IDLE           | watching EX for trap/mret events
// WR_MEPC        | writing faulting/interrupted PC to mepc
// WR_MCAUSE      | writing trap cause to mcause
// WR_MSTATUS     | MPIE <= MIE, MIE <= 0
// ASSERT_TRAP    | redirect fetch to mtvec base
// WR_MSTATUS_RET | MIE <= MPIE, MPIE <= 1
// ASSERT_RET     | redirect fetch to mepc
module clint_ctrl
  import clint_pkg::*;
#(
  parameter int          IRQ_SYNC_STAGES = 2,
  parameter logic [31:0] CAUSE_EXT_IRQ   = CAUSE_EXT_IRQ_DEF,
  parameter logic [31:0] CAUSE_ECALL     = CAUSE_ECALL_DEF,
  parameter logic [31:0] CAUSE_EBREAK    = CAUSE_EBREAK_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_i,
  input  logic [31:0] inst_addr_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        ex_busy_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mstatus_i,
  output logic        csr_we_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        stall_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  state_t      state, state_nxt;
  logic [31:0] epc, cause;
  logic        irq_s;
  logic        irq_take;
  logic        trap_take;
  logic [31:0] trap_cause;
  logic [31:0] ms_wdata;
  logic        unused_mtvec;

  assign unused_mtvec = ^mtvec_i[1:0];

  sync_ff #(.STAGES(IRQ_SYNC_STAGES)) u_irq_sync (
    .clk (clk),
    .rst (rst),
    .d   (irq_i),
    .q   (irq_s)
  );

  assign irq_take = irq_s & mstatus_i[MSTATUS_MIE_BIT] & ~ex_busy_i;

  // State register plus epc/cause capture on the detect cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      epc   <= '0;
      cause <= '0;
    end else begin
      state <= state_nxt;
      if (trap_take) begin
        epc   <= inst_addr_i;
        cause <= trap_cause;
      end
    end
  end

  // Event detect, next state and all sequencer outputs.
  always_comb begin
    state_nxt    = state;
    trap_take    = 1'b0;
    trap_cause   = '0;
    csr_we_o     = 1'b0;
    csr_waddr_o  = '0;
    csr_wdata_o  = '0;
    stall_o      = 1'b0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    ms_wdata     = mstatus_i;
    case (state)
      IDLE: begin
        // Gated by rst so nothing starts (or stalls) while reset is held.
        if (!rst) begin
          if (ecall_i) begin
            trap_take  = 1'b1;
            trap_cause = CAUSE_ECALL;
          end else if (ebreak_i) begin
            trap_take  = 1'b1;
            trap_cause = CAUSE_EBREAK;
          end else if (mret_i) begin
            state_nxt = WR_MSTATUS_RET;
            stall_o   = 1'b1;
          end else if (irq_take) begin
            trap_take  = 1'b1;
            trap_cause = CAUSE_EXT_IRQ;
          end
          if (trap_take) begin
            state_nxt = WR_MEPC;
            stall_o   = 1'b1;
          end
        end
      end
      WR_MEPC: begin
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = epc;
        state_nxt   = WR_MCAUSE;
      end
      WR_MCAUSE: begin
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = cause;
        state_nxt   = WR_MSTATUS;
      end
      WR_MSTATUS: begin
        ms_wdata[MSTATUS_MPIE_BIT] = mstatus_i[MSTATUS_MIE_BIT];
        ms_wdata[MSTATUS_MIE_BIT]  = 1'b0;
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = ms_wdata;
        state_nxt   = ASSERT_TRAP;
      end
      ASSERT_TRAP: begin
        stall_o      = 1'b1;
        int_assert_o = 1'b1;
        int_addr_o   = {mtvec_i[31:2], 2'b00};
        state_nxt    = IDLE;
      end
      WR_MSTATUS_RET: begin
        ms_wdata[MSTATUS_MIE_BIT]  = mstatus_i[MSTATUS_MPIE_BIT];
        ms_wdata[MSTATUS_MPIE_BIT] = 1'b1;
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = ms_wdata;
        state_nxt   = ASSERT_RET;
      end
      ASSERT_RET: begin
        stall_o      = 1'b1;
        int_assert_o = 1'b1;
        int_addr_o   = mepc_i;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
